arbitro_vc: RTL and testbench

- Weighted arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the switch datapath.
- Gated by the control FSM's active output.
- Pops one word per cycle from the winning VC, steers it to D0 or D1 by its destination bit, and honours D0/D1 almost_full backpressure.
- Sits between the VC FIFOs and the destination FIFOs, alongside the FSM control block.

---
 rtl/arbitro_vc.sv | 114 +++++++++++
 tb/tb_arbitro_vc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_vc.sv
// Weighted two-VC arbiter: pops one word per cycle from VC0/VC1 and steers it to D0/D1
// by its destination bit, honouring destination almost_full and the control FSM's active gate.
module arbitro_vc #(
  parameter int BW         = 6,
  parameter int VC0_WEIGHT = 4,
  parameter int WW         = 3,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          active,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic          d0_almost_full,
  input  logic          d1_almost_full,
  output logic          pop_vc0,
  output logic          pop_vc1,
  output logic          push_d0,
  output logic          push_d1,
  output logic [BW-1:0] data_out,
  output logic [1:0]    arb_state,
  output logic [CW-1:0] cnt_d0,
  output logic [CW-1:0] cnt_d1
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SRV0 = 2'b01,
    SRV1 = 2'b10
  } arb_state_t;

  localparam logic [WW-1:0] WEIGHT_MAX = WW'(VC0_WEIGHT);

  arb_state_t    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          push_d0_q, push_d0_d;
  logic          push_d1_q, push_d1_d;
  logic [BW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_d0_q, cnt_d0_d;
  logic [CW-1:0] cnt_d1_q, cnt_d1_d;

  logic vc0_af, vc1_af;
  logic elig0, elig1;
  logic gnt0, gnt1;

  // Each VC only looks at the destination its own head word targets, so a
  // blocked head on one VC never stalls the other.
  always_comb begin
    vc0_af = vc0_data[BW-1] ? d1_almost_full : d0_almost_full;
    vc1_af = vc1_data[BW-1] ? d1_almost_full : d0_almost_full;
    elig0  = active & ~vc0_empty & ~vc0_af;
    elig1  = active & ~vc1_empty & ~vc1_af;
    gnt1   = elig1 & (~elig0 | (wcnt_q == WEIGHT_MAX));
    gnt0   = elig0 & ~gnt1;
  end

  assign pop_vc0 = gnt0 & ~reset;
  assign pop_vc1 = gnt1 & ~reset;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d   = IDLE;
    wcnt_d    = wcnt_q;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    data_d    = data_q;
    cnt_d0_d  = cnt_d0_q + CW'(push_d0_q);
    cnt_d1_d  = cnt_d1_q + CW'(push_d1_q);
    if (gnt0) begin
      state_d   = SRV0;
      data_d    = vc0_data;
      push_d0_d = ~vc0_data[BW-1];
      push_d1_d = vc0_data[BW-1];
      if (wcnt_q != WEIGHT_MAX) wcnt_d = wcnt_q + 1'b1;
    end else if (gnt1) begin
      state_d   = SRV1;
      data_d    = vc1_data;
      push_d0_d = ~vc1_data[BW-1];
      push_d1_d = vc1_data[BW-1];
      wcnt_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
      cnt_d0_q  <= '0;
      cnt_d1_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_q    <= data_d;
      cnt_d0_q  <= cnt_d0_d;
      cnt_d1_q  <= cnt_d1_d;
    end
  end

  assign push_d0   = push_d0_q;
  assign push_d1   = push_d1_q;
  assign data_out  = data_q;
  assign arb_state = state_q;
  assign cnt_d0    = cnt_d0_q;
  assign cnt_d1    = cnt_d1_q;

endmodule

// File: tb/tb_arbitro_vc.sv
// Directed bench for arbitro_vc: FWFT VC FIFOs modelled as queues, expected values hand-computed.
module tb_arbitro_vc;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       d0_almost_full, d1_almost_full;
  logic       pop_vc0, pop_vc1, push_d0, push_d1;
  logic [5:0] data_out;
  logic [1:0] arb_state;
  logic [7:0] cnt_d0, cnt_d1;

  logic [5:0] q0[$];
  logic [5:0] q1[$];

  int n_cmp  = 0;
  int n_fail = 0;

  arbitro_vc #(.BW(6), .VC0_WEIGHT(4), .WW(3), .CW(8)) dut (
    .clk(clk), .reset(reset), .active(active),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .arb_state(arb_state),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = vc0_empty ? 6'h00 : q0[0];
    vc1_data  = vc1_empty ? 6'h00 : q1[0];
  endtask

  // Pops are sampled before the edge; queues advance at the edge, inputs change at negedge.
  task automatic tick();
    logic p0, p1;
    p0 = pop_vc0;
    p1 = pop_vc1;
    @(posedge clk);
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic pat [10];
    int   n0, n1;
    logic [5:0] exp_d;

    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    active = 1'b1;
    d0_almost_full = 1'b0;
    d1_almost_full = 1'b0;
    q0 = '{6'h05, 6'h25, 6'h07};
    drive();
    @(negedge clk);
    #1;

    // Reset state, pops forced low while reset is high
    check("rst_pop0", pop_vc0, 0);
    check("rst_pop1", pop_vc1, 0);
    check("rst_push0", push_d0, 0);
    check("rst_push1", push_d1, 0);
    check("rst_data", data_out, 0);
    check("rst_state", arb_state, 2'b00);
    check("rst_cnt0", cnt_d0, 0);
    check("rst_cnt1", cnt_d1, 0);

    // Single VC0 stream
    reset = 1'b0;
    #1;
    check("a_pop0_first", pop_vc0, 1);
    tick();
    check("a1_push0", push_d0, 1);
    check("a1_push1", push_d1, 0);
    check("a1_data", data_out, 6'h05);
    check("a1_state", arb_state, 2'b01);
    tick();
    check("a2_push0", push_d0, 0);
    check("a2_push1", push_d1, 1);
    check("a2_data", data_out, 6'h25);
    check("a2_cnt0", cnt_d0, 1);
    tick();
    check("a3_push0", push_d0, 1);
    check("a3_data", data_out, 6'h07);
    check("a3_cnt1", cnt_d1, 1);
    check("a3_pop0_empty", pop_vc0, 0);
    tick();
    check("a4_push0", push_d0, 0);
    check("a4_push1", push_d1, 0);
    check("a4_data_hold", data_out, 6'h07);
    check("a4_state", arb_state, 2'b00);
    check("a4_cnt0", cnt_d0, 2);
    check("a4_cnt1", cnt_d1, 1);

    // Reset mid-stream with push_d1 in flight
    q0 = '{6'h21, 6'h22};
    drive();
    #1;
    tick();
    check("b_push1", push_d1, 1);
    check("b_data", data_out, 6'h21);
    reset = 1'b1;
    #1;
    check("b_rst_push1", push_d1, 0);
    check("b_rst_data", data_out, 0);
    check("b_rst_cnt0", cnt_d0, 0);
    check("b_rst_cnt1", cnt_d1, 0);
    check("b_rst_state", arb_state, 2'b00);
    check("b_rst_pop0", pop_vc0, 0);
    tick();
    check("b_rst_pop0_held", pop_vc0, 0);
    check("b_rst_push1_held", push_d1, 0);
    q0.delete();
    drive();
    reset = 1'b0;
    #1;

    // Weighting: both VCs loaded with D0-bound words
    for (int n = 0; n < 16; n++) begin
      q0.push_back(6'h01 + 6'(n));
      q1.push_back(6'h11 + 6'(n));
    end
    drive();
    #1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("c%0d_pop1", i), pop_vc1, pat[i]);
      check($sformatf("c%0d_pop0", i), pop_vc0, !pat[i]);
      if (pat[i]) begin
        exp_d = 6'h11 + 6'(n1);
        n1++;
      end else begin
        exp_d = 6'h01 + 6'(n0);
        n0++;
      end
      tick();
      check($sformatf("c%0d_state", i), arb_state, pat[i] ? 2'b10 : 2'b01);
      check($sformatf("c%0d_data", i), data_out, exp_d);
    end

    // Gating: wcnt goes to 2, active drops, then resumes from the held count
    check("d_pop0_a", pop_vc0, 1);
    tick();
    check("d_data_a", data_out, 6'h09);
    check("d_pop0_b", pop_vc0, 1);
    tick();
    check("d_data_b", data_out, 6'h0A);
    active = 1'b0;
    #1;
    check("d_gate_pop0", pop_vc0, 0);
    check("d_gate_pop1", pop_vc1, 0);
    check("d_gate_push0", push_d0, 1);
    check("d_gate_data", data_out, 6'h0A);
    tick();
    check("d_idle_push0", push_d0, 0);
    check("d_idle_state", arb_state, 2'b00);
    check("d_idle_data", data_out, 6'h0A);
    tick();
    active = 1'b1;
    #1;
    check("d_res_pop0_a", pop_vc0, 1);
    tick();
    check("d_res_data_a", data_out, 6'h0B);
    check("d_res_pop0_b", pop_vc0, 1);
    tick();
    check("d_res_data_b", data_out, 6'h0C);
    check("d_res_pop1", pop_vc1, 1);
    check("d_res_pop0_c", pop_vc0, 0);
    tick();
    check("d_res_data_c", data_out, 6'h13);
    check("d_res_state", arb_state, 2'b10);

    // Backpressure bypass: VC0 head to D1 blocked, VC1 to D0 flows
    do_reset();
    d1_almost_full = 1'b1;
    q0 = '{6'h30, 6'h31};
    q1 = '{6'h02, 6'h03, 6'h04};
    drive();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("e%0d_pop0", i), pop_vc0, 0);
      check($sformatf("e%0d_pop1", i), pop_vc1, 1);
      tick();
      check($sformatf("e%0d_data", i), data_out, 6'h02 + 6'(i));
      check($sformatf("e%0d_push0", i), push_d0, 1);
    end
    check("e_blocked_pop0", pop_vc0, 0);
    d1_almost_full = 1'b0;
    #1;
    check("e_release_pop0", pop_vc0, 1);
    tick();
    check("e_push1", push_d1, 1);
    check("e_data", data_out, 6'h30);
    check("e_cnt0", cnt_d0, 3);
    check("e_cnt1", cnt_d1, 0);

    // Counter wrap: 256 D0 pushes
    do_reset();
    for (int n = 0; n < 256; n++) q0.push_back(6'h01);
    drive();
    #1;
    repeat (256) tick();
    check("f_cnt0_255", cnt_d0, 255);
    check("f_push0_last", push_d0, 1);
    tick();
    check("f_cnt0_wrap", cnt_d0, 0);
    check("f_cnt1", cnt_d1, 0);
    check("f_push0_done", push_d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
